// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush controller for the 5-stage MIPS pipeline.
// Resolves hazards that forwarding cannot: load/mfc0 use in the next
// instruction, HI/LO users behind the multi-cycle mult/div unit, taken
// branches and exceptions. Tracks the mult/div busy window with a small FSM.
//
// Ports:
//   clk, reset        core clock, synchronous active-high reset
//   id_rs, id_rt      source registers of the ID instruction
//   id_hilo_use       ID instruction touches HI/LO or is mult/div
//   ex_rw, ex_regWr   EX destination register and write enable
//   ex_memtoreg       EX writeback source (0 ALU, 1 load, 2 cp0)
//   ex_md_start       EX instruction is a valid mult/div
//   ex_md_is_div      1 = div/divu, 0 = mult/multu
//   ex_branch_taken   branch/jump resolved taken in EX
//   mem_exc           exception/eret taken in MEM
//   pc_stall, ifid_stall                     hold PC / IF-ID (combinational)
//   ifid_flush, idex_flush, exmem_flush      stage bubbles (combinational)
//   md_busy           mult/div in progress (registered)
//   md_done           one-cycle pulse, HI/LO valid (registered)
//   stall_cycles      count of cycles with pc_stall=1 (registered)
module hazard_ctrl #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_hilo_use,
  input  logic [4:0]  ex_rw,
  input  logic        ex_regWr,
  input  logic [1:0]  ex_memtoreg,
  input  logic        ex_md_start,
  input  logic        ex_md_is_div,
  input  logic        ex_branch_taken,
  input  logic        mem_exc,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cycles
);

  // The EX cycle itself counts as one busy cycle, so the counter loads N-1.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, load_val;
  logic             done_d;
  logic             load_use, md_hold;

  assign md_busy = (state_q == BUSY);

  // Hazard detection and prioritised stall/flush strobes.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;

    load_use = ex_regWr && (ex_rw != 5'd0) && (ex_memtoreg != 2'd0) &&
               ((ex_rw == id_rs) || (ex_rw == id_rt));
    // ex_md_start covers the issue cycle, before md_busy has risen.
    md_hold  = id_hilo_use && (md_busy || ex_md_start);

    if (mem_exc) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (md_hold || load_use) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
    end
  end

  // Mult/div busy-window sequencing.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    load_val = ex_md_is_div ? DIV_LOAD : MUL_LOAD;

    case (state_q)
      IDLE: begin
        if (ex_md_start && !mem_exc) begin
          cnt_d = load_val;
          if (load_val == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        // A start while busy is illegal and ignored; mem_exc aborts silently.
        if (mem_exc) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, done pulse and stall counter; reset overrides any abort or done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      md_done      <= 1'b0;
      stall_cycles <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      md_done <= done_d;
      if (pc_stall) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
    end
  end

endmodule
